rr_stream_mux: RTL and testbench

- Parametrised N:1 packet-stream multiplexer; successor to the combinational 4:1 mux.
- Adds valid/ready handshake per channel, packet locking (grant held until a `last` beat), a runtime-selectable fixed-select or round-robin mode, and a registered output stage.
- Sits between N producer streams and one shared consumer, e.g. several UART/test-pattern sources feeding one sink.

---
 rtl/rr_stream_mux_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/rr_stream_mux.sv | 179 +++++++++++++++++
 tb/tb_rr_stream_mux.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_stream_mux_pkg.sv
// Shared definitions for the round-robin packet stream multiplexer:
// mode encodings and the packet-lock state machine states.
package rr_stream_mux_pkg;

    // Selection modes driven on the `mode` input.
    localparam logic MODE_SEL = 1'b0;  // fixed channel chosen by `sel`
    localparam logic MODE_RR  = 1'b1;  // rotating priority between channels

    // Packet-lock states. ST_LOCK means a multi-beat packet is in flight and
    // the grant is pinned to the locked channel until its `last` beat.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    localparam state_t ST_RESET = ST_IDLE;

endpackage : rr_stream_mux_pkg

// File: rtl/rr_arbiter.sv
// Rotate-priority pick: returns the first requesting channel found when
// searching upward from (ptr + 1) mod N, wrapping around. Purely combinational.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int CW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    output logic [CW-1:0] gnt_idx,
    output logic          gnt_ok
);

    int          idx;
    logic [CW-1:0] idx_c;

    // Walk offsets 1..N from the pointer; the first request seen wins.
    always_comb begin
        gnt_idx = '0;
        gnt_ok  = 1'b0;
        idx     = 0;
        idx_c   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_c = CW'(idx);
            if (!gnt_ok && req[idx_c]) begin
                gnt_idx = idx_c;
                gnt_ok  = 1'b1;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/rr_stream_mux.sv
// N:1 packet stream multiplexer with per-channel valid/ready, packet locking
// (grant held until a `last` beat), fixed-select or round-robin arbitration
// and a single registered output stage.
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are high. Valid never waits on ready. in_ready is one-hot
// or zero and depends on out_ready only through the output stage being full
// (load = !out_valid | out_ready); while out_valid is high and out_ready low,
// every out_* signal holds stable.
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int CW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [CW-1:0]  sel,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    input  logic [N-1:0]   in_last,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    output logic           out_last,
    output logic [CW-1:0]  out_ch,
    input  logic           out_ready,
    output logic           busy
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t        state_q,     state_d;
    logic [CW-1:0] locked_q,    locked_d;
    logic [CW-1:0] rr_ptr_q,    rr_ptr_d;
    logic [W-1:0]  out_data_q,  out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q,  out_last_d;
    logic [CW-1:0] out_ch_q,    out_ch_d;

    // ------------------------------------------------------------------
    // Combinational datapath signals
    // ------------------------------------------------------------------
    logic [W-1:0]  ch_data [N];
    logic [CW-1:0] arb_idx;
    logic          arb_ok;
    logic [CW-1:0] g;
    logic          grant_ok;
    logic          load;
    logic          xfer;
    logic          last_g;
    logic [W-1:0]  data_g;

    // Unpack the flattened input bus into one word per channel.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            ch_data[k] = in_data[k*W +: W];
        end
    end

    rr_arbiter #(
        .N  (N),
        .CW (CW)
    ) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (arb_idx),
        .gnt_ok  (arb_ok)
    );

    // Output stage can take a beat when empty or being drained this cycle.
    assign load = !out_valid_q || out_ready;

    // Pick the grant candidate: the locked channel mid-packet, otherwise the
    // arbiter result or the fixed select depending on mode.
    always_comb begin
        g        = '0;
        grant_ok = 1'b0;
        if (state_q == ST_LOCK) begin
            g        = locked_q;
            grant_ok = in_valid[locked_q];
        end else if (mode == MODE_RR) begin
            g        = arb_idx;
            grant_ok = arb_ok;
        end else begin
            g = sel;
            if (int'(sel) < N) begin
                grant_ok = in_valid[sel];
            end
        end
    end

    // Reset gates the grant so in_ready is low for the whole reset window.
    assign xfer   = grant_ok && load && rst_n;
    assign last_g = in_last[g];
    assign data_g = ch_data[g];

    // Drive ready only on the granted channel.
    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[g] = 1'b1;
        end
    end

    // Packet-lock FSM: next state, locked channel and round-robin pointer.
    always_comb begin
        state_d  = state_q;
        locked_d = locked_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    rr_ptr_d = g;
                    if (!last_g) begin
                        state_d  = ST_LOCK;
                        locked_d = g;
                    end
                end
            end
            ST_LOCK: begin
                if (xfer && last_g) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output register: load a granted beat, drop valid when drained with
    // nothing new, hold everything while stalled.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        if (load) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = data_g;
                out_last_d = last_g;
                out_ch_d   = g;
            end
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET;
            locked_q    <= '0;
            rr_ptr_q    <= CW'(N - 1);
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            locked_q    <= locked_d;
            rr_ptr_q    <= rr_ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;
    assign busy      = (state_q == ST_LOCK);

endmodule : rr_stream_mux

// File: tb/tb_rr_stream_mux.sv
// Testbench for rr_stream_mux: reset values, a grant vector table, hand-built
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_rr_stream_mux;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 2;

    // ------------------------------------------------------------------
    // Clock / reset and DUT signals
    // ------------------------------------------------------------------
    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           mode      = 1'b0;
    logic [CW-1:0]  sel       = '0;
    logic [N*W-1:0] in_data   = '0;
    logic [N-1:0]   in_valid  = '0;
    logic [N-1:0]   in_last   = '0;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_last;
    logic [CW-1:0]  out_ch;
    logic           out_ready = 1'b1;
    logic           busy;

    // Three-channel instance for the out-of-range select case.
    logic [3*W-1:0] in_data3   = '0;
    logic [2:0]     in_valid3  = '0;
    logic [2:0]     in_last3   = 3'b111;
    logic [2:0]     in_ready3;
    logic [W-1:0]   out_data3;
    logic           out_valid3;
    logic           out_last3;
    logic [CW-1:0]  out_ch3;
    logic           out_ready3 = 1'b1;
    logic           busy3;

    always #5 clk = ~clk;

    rr_stream_mux #(.N(N), .W(W), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ch    (out_ch),
        .out_ready (out_ready),
        .busy      (busy)
    );

    rr_stream_mux #(.N(3), .W(W), .CW(CW)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_last   (in_last3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_last  (out_last3),
        .out_ch    (out_ch3),
        .out_ready (out_ready3),
        .busy      (busy3)
    );

    // ------------------------------------------------------------------
    // Scoreboard bookkeeping
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit vbit(input logic [N-1:0] v, input int k);
        return ((v >> k) & N'(1)) != '0;
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic set_ch(input int k, input logic v, input logic l, input logic [W-1:0] d);
        logic [N-1:0]   m;
        logic [N*W-1:0] dm;
        m  = N'(1) << k;
        dm = {{(N*W-W){1'b0}}, {W{1'b1}}} << (k * W);
        in_valid = v ? (in_valid | m) : (in_valid & ~m);
        in_last  = l ? (in_last | m) : (in_last & ~m);
        in_data  = (in_data & ~dm) | ((N*W)'(d) << (k * W));
    endtask

    // Leaves the bench at a falling edge with reset just released.
    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Grant vector table: each entry starts from a fresh reset
    // (IDLE, rr_ptr = N-1, output empty); channel k carries data 8'hC0+k.
    // ------------------------------------------------------------------
    typedef struct {
        logic          mode;
        logic [CW-1:0] sel;
        logic [N-1:0]  valid;
        logic [N-1:0]  ready_exp;
        logic [CW-1:0] ch_exp;
    } vec_t;

    vec_t vecs [9];

    // Randomized-run reference model state.
    int          m_lock;
    int          m_last;
    bit          m_full;
    int          pick;
    int          c;
    bit          lbit;
    logic [N-1:0] exp_ready;
    logic [CW+W:0] exp_q [$];
    logic [CW+W:0] beat;

    initial begin
        vecs[0] = '{1'b1, 2'd0, 4'b1111, 4'b0001, 2'd0};
        vecs[1] = '{1'b1, 2'd0, 4'b0110, 4'b0010, 2'd1};
        vecs[2] = '{1'b1, 2'd0, 4'b1000, 4'b1000, 2'd3};
        vecs[3] = '{1'b1, 2'd0, 4'b0000, 4'b0000, 2'd0};
        vecs[4] = '{1'b0, 2'd2, 4'b0100, 4'b0100, 2'd2};
        vecs[5] = '{1'b0, 2'd2, 4'b1011, 4'b0000, 2'd0};
        vecs[6] = '{1'b0, 2'd1, 4'b1111, 4'b0010, 2'd1};
        vecs[7] = '{1'b0, 2'd3, 4'b1000, 4'b1000, 2'd3};
        vecs[8] = '{1'b1, 2'd0, 4'b1100, 4'b0100, 2'd2};

        // ---------------- reset values ----------------
        in_valid = 4'b1111;
        in_last  = 4'b1111;
        mode     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data), 32'd0);
        check("rst_out_last",  32'(out_last), 32'd0);
        check("rst_out_ch",    32'(out_ch), 32'd0);
        check("rst_busy",      32'(busy), 32'd0);

        // ---------------- grant vector table ----------------
        for (int i = 0; i < 9; i++) begin
            do_reset();
            mode = vecs[i].mode;
            sel  = vecs[i].sel;
            for (int k = 0; k < N; k++) begin
                set_ch(k, vbit(vecs[i].valid, k), 1'b1, 8'(8'hC0 + k));
            end
            #1;
            check("vec_in_ready", 32'(in_ready), 32'(vecs[i].ready_exp));
            @(negedge clk);
            check("vec_out_valid", 32'(out_valid), 32'(vecs[i].ready_exp != '0));
            if (vecs[i].ready_exp != '0) begin
                check("vec_out_ch", 32'(out_ch), 32'(vecs[i].ch_exp));
                check("vec_out_data", 32'(out_data), 32'hC0 + 32'(vecs[i].ch_exp));
            end
        end

        // ---------------- round-robin sweep, single-beat packets ----------------
        do_reset();
        mode = 1'b1;
        for (int k = 0; k < N; k++) set_ch(k, 1'b1, 1'b1, 8'(8'h10 + k));
        #1;
        check("rr_first_ready", 32'(in_ready), 32'b0001);
        check("rr_first_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rr_out_valid", 32'(out_valid), 32'd1);
            check("rr_out_ch", 32'(out_ch), 32'(i % 4));
            check("rr_out_data", 32'(out_data), 32'h10 + 32'(i % 4));
        end

        // ---------------- packet lock against a competing channel ----------------
        do_reset();
        mode = 1'b1;
        set_ch(1, 1'b1, 1'b0, 8'hA1);
        set_ch(2, 1'b1, 1'b1, 8'hB0);
        #1;
        check("lock_ready_a1", 32'(in_ready), 32'b0010);
        @(negedge clk);
        check("lock_data_a1", 32'(out_data), 32'hA1);
        check("lock_ch_a1", 32'(out_ch), 32'd1);
        check("lock_busy_a1", 32'(busy), 32'd1);
        set_ch(1, 1'b1, 1'b0, 8'hA2);
        #1;
        check("lock_ready_a2", 32'(in_ready), 32'b0010);
        @(negedge clk);
        check("lock_data_a2", 32'(out_data), 32'hA2);
        check("lock_busy_a2", 32'(busy), 32'd1);
        set_ch(1, 1'b1, 1'b1, 8'hA3);
        #1;
        check("lock_ready_a3", 32'(in_ready), 32'b0010);
        @(negedge clk);
        check("lock_data_a3", 32'(out_data), 32'hA3);
        check("lock_last_a3", 32'(out_last), 32'd1);
        check("lock_busy_end", 32'(busy), 32'd0);
        #1;
        check("lock_ready_next", 32'(in_ready), 32'b0100);
        @(negedge clk);
        check("lock_next_ch", 32'(out_ch), 32'd2);
        check("lock_next_data", 32'(out_data), 32'hB0);

        // ---------------- fixed select, sel change mid-packet ----------------
        do_reset();
        mode = 1'b0;
        sel  = 2'd2;
        set_ch(2, 1'b1, 1'b0, 8'h55);
        set_ch(0, 1'b1, 1'b1, 8'h0E);
        #1;
        check("sel_ready_55", 32'(in_ready), 32'b0100);
        @(negedge clk);
        check("sel_data_55", 32'(out_data), 32'h55);
        check("sel_ch_55", 32'(out_ch), 32'd2);
        check("sel_busy_55", 32'(busy), 32'd1);
        sel = 2'd0;
        set_ch(2, 1'b1, 1'b1, 8'h66);
        #1;
        check("sel_ready_66", 32'(in_ready), 32'b0100);
        @(negedge clk);
        check("sel_data_66", 32'(out_data), 32'h66);
        check("sel_ch_66", 32'(out_ch), 32'd2);
        check("sel_busy_66", 32'(busy), 32'd0);
        #1;
        check("sel_ready_ch0", 32'(in_ready), 32'b0001);
        @(negedge clk);
        check("sel_ch0", 32'(out_ch), 32'd0);
        check("sel_data_ch0", 32'(out_data), 32'h0E);
        in_valid  = '0;
        sel       = 2'd3;
        in_valid3 = 3'b111;
        #1;
        check("sel_oob_ready", 32'(in_ready3), 32'd0);
        @(negedge clk);
        check("sel_oob_busy", 32'(busy3), 32'd0);
        check("sel_oob_valid", 32'(out_valid3), 32'd0);
        in_valid3 = '0;

        // ---------------- backpressure ----------------
        do_reset();
        mode = 1'b1;
        set_ch(0, 1'b1, 1'b1, 8'h3C);
        @(negedge clk);
        check("bp_first", 32'(out_data), 32'h3C);
        out_ready = 1'b0;
        set_ch(0, 1'b1, 1'b1, 8'h3D);
        for (int j = 0; j < 3; j++) begin
            #1;
            check("bp_ready_low", 32'(in_ready), 32'd0);
            @(negedge clk);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", 32'(out_data), 32'h3C);
        end
        out_ready = 1'b1;
        #1;
        check("bp_ready_back", 32'(in_ready), 32'b0001);
        @(negedge clk);
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_data", 32'(out_data), 32'h3D);

        // ---------------- bubble inside a locked packet ----------------
        do_reset();
        mode = 1'b1;
        set_ch(0, 1'b1, 1'b0, 8'h01);
        set_ch(1, 1'b1, 1'b1, 8'h11);
        @(negedge clk);
        check("bub_busy", 32'(busy), 32'd1);
        set_ch(0, 1'b0, 1'b0, 8'h00);
        for (int j = 0; j < 2; j++) begin
            #1;
            check("bub_no_grant", 32'(in_ready), 32'd0);
            @(negedge clk);
            check("bub_valid_low", 32'(out_valid), 32'd0);
            check("bub_busy_hold", 32'(busy), 32'd1);
        end
        set_ch(0, 1'b1, 1'b1, 8'h02);
        #1;
        check("bub_resume_ready", 32'(in_ready), 32'b0001);
        @(negedge clk);
        check("bub_resume_data", 32'(out_data), 32'h02);
        check("bub_resume_ch", 32'(out_ch), 32'd0);
        check("bub_done_busy", 32'(busy), 32'd0);

        // ---------------- reset mid-packet ----------------
        do_reset();
        mode = 1'b1;
        set_ch(1, 1'b1, 1'b0, 8'h77);
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_valid", 32'(out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) set_ch(k, 1'b1, 1'b1, 8'(8'h20 + k));
        #1;
        check("mid_restart_ready", 32'(in_ready), 32'b0001);

        // ---------------- randomized run against the model ----------------
        do_reset();
        mode   = 1'b1;
        m_lock = -1;
        m_last = N - 1;
        m_full = 1'b0;
        exp_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 7) == 0) sel = CW'($urandom_range(0, N - 1));
            for (int k = 0; k < N; k++) begin
                set_ch(k, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
                       W'($urandom_range(0, 255)));
            end
            out_ready = $urandom_range(0, 3) != 0;
            #1;

            // Expected grant from the rules: locked channel, else rotating
            // search after the last granted channel, else the selected one.
            pick = -1;
            if (m_lock >= 0) begin
                if (vbit(in_valid, m_lock)) pick = m_lock;
            end else if (mode) begin
                for (int off = 1; off <= N; off++) begin
                    c = (m_last + off) % N;
                    if (pick < 0 && vbit(in_valid, c)) pick = c;
                end
            end else if (vbit(in_valid, int'(sel))) begin
                pick = int'(sel);
            end
            if (m_full && !out_ready) pick = -1;
            exp_ready = (pick >= 0) ? (N'(1) << pick) : '0;

            check("rand_in_ready", 32'(in_ready), 32'(exp_ready));
            check("rand_out_valid", 32'(out_valid), 32'(m_full));
            check("rand_busy", 32'(busy), 32'(m_lock >= 0));

            if (m_full && out_ready) begin
                if (exp_q.size() > 0) begin
                    beat = exp_q.pop_front();
                    check("rand_beat", 32'({out_ch, out_last, out_data}), 32'(beat));
                end
                m_full = 1'b0;
            end
            if (pick >= 0) begin
                lbit = vbit(in_last, pick);
                exp_q.push_back({pick[CW-1:0], lbit, W'(in_data >> (pick * W))});
                m_full = 1'b1;
                if (m_lock < 0) begin
                    m_last = pick;
                    if (!lbit) m_lock = pick;
                end else if (lbit) begin
                    m_lock = -1;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rr_stream_mux
